// File: rtl/kamus_lsu.sv
// kamus_lsu: load/store unit driving a req/gnt/rvalid L1D port, returns extended load data.
// Latency: store done 2 cycles after accept (gnt immediate), load done/rdata 3 cycles after accept.
// Backpressure: lsu_busy_o stalls the pipeline while an op is outstanding; req held until gnt.
module kamus_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_valid_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_done_o,
  output logic              lsu_busy_o,
  output logic              lsu_misalign_o,
  output logic              l1d_req_o,
  output logic              l1d_we_o,
  output logic [ADDR_W-1:0] l1d_addr_o,
  output logic [3:0]        l1d_be_o,
  output logic [XLEN-1:0]   l1d_wdata_o,
  input  logic              l1d_gnt_i,
  input  logic              l1d_rvalid_i,
  input  logic [XLEN-1:0]   l1d_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              done_q;
  logic              misalign_q;

  // Access size comes from funct3[1:0]; 10 and 11 (incl. unused encodings) are word ops.
  logic              in_b;
  logic              in_h;
  logic              misalign_d;
  logic [3:0]        be_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   lword;
  logic [XLEN-1:0]   ldata_d;

  assign in_b       = (lsu_funct3_i[1:0] == 2'b00);
  assign in_h       = (lsu_funct3_i[1:0] == 2'b01);
  assign misalign_d = (in_h & lsu_addr_i[0]) |
                      (!in_b & !in_h & (lsu_addr_i[1:0] != 2'b00));
  assign be_d       = in_b ? (4'b0001 << lsu_addr_i[1:0]) :
                      in_h ? (4'b0011 << lsu_addr_i[1:0]) : 4'b1111;
  assign wdata_d    = in_b ? {4{lsu_wdata_i[7:0]}} :
                      in_h ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;

  // Align the returned word to the addressed lane, then sign/zero-extend by latched funct3.
  always_comb begin
    lword = l1d_rdata_i >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   ldata_d = funct3_q[2] ? {24'b0, lword[7:0]}  : {{24{lword[7]}}, lword[7:0]};
      2'b01:   ldata_d = funct3_q[2] ? {16'b0, lword[15:0]} : {{16{lword[15]}}, lword[15:0]};
      default: ldata_d = lword;
    endcase
  end

  // Control FSM; all port-facing state is registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lsu_valid_i) begin
            if (misalign_d) begin
              misalign_q <= 1'b1;
            end else begin
              addr_q   <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
              off_q    <= lsu_addr_i[1:0];
              we_q     <= lsu_we_i;
              funct3_q <= lsu_funct3_i;
              be_q     <= be_d;
              wdata_q  <= wdata_d;
              state_q  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // rvalid coincident with gnt is a protocol violation and is not looked at here.
          if (l1d_gnt_i) begin
            if (we_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (l1d_rvalid_i) begin
            rdata_q <= ldata_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign l1d_req_o      = (state_q == S_REQ);
  assign lsu_busy_o     = (state_q != S_IDLE);
  assign l1d_we_o       = we_q;
  assign l1d_addr_o     = addr_q;
  assign l1d_be_o       = be_q;
  assign l1d_wdata_o    = wdata_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_done_o     = done_q;
  assign lsu_misalign_o = misalign_q;

endmodule
